// File: rtl/ula_pkg.sv
// Shared constants for the ULA: opcode encodings and the default datapath width.
package ula_pkg;

  localparam int ULA_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_EQ  = 3'b110;
  localparam logic [2:0] OP_NEQ = 3'b111;

endpackage

// File: rtl/ula_core.sv
// Purely combinational ULA datapath. Carry/zero flags exist only when ULA_FLAGS_EN is defined.
module ula_core
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       opcode_i,
  output logic [WIDTH-1:0] result_o
`ifdef ULA_FLAGS_EN
  ,
  output logic             carry_o,
  output logic             zero_o
`endif
);

  // An opcode that matches no item (including X/Z in simulation) falls to the zero default.
  always_comb begin
    result_o = {WIDTH{1'b0}};
    case (opcode_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOT:  result_o = ~a_i;
      OP_EQ:   result_o = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      OP_NEQ:  result_o = {{(WIDTH-1){1'b0}}, (a_i != b_i)};
      default: result_o = {WIDTH{1'b0}};
    endcase
  end

`ifdef ULA_FLAGS_EN
  // a + b overflows exactly when a exceeds the largest value b can still be added to.
  always_comb begin
    carry_o = 1'b0;
    case (opcode_i)
      OP_ADD:  carry_o = (a_i > ~b_i);
      OP_SUB:  carry_o = (a_i < b_i);
      default: carry_o = 1'b0;
    endcase
  end

  assign zero_o = (result_o == {WIDTH{1'b0}});
`endif

endmodule

// File: rtl/ula.sv
// ULA top: registers the ula_core result (and flags when ULA_FLAGS_EN is defined)
// with one-cycle latency and asynchronous active-low reset.
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] s
`ifdef ULA_FLAGS_EN
  ,
  output logic             carry,
  output logic             zero
`endif
);

  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] s_q;

`ifdef ULA_FLAGS_EN
  logic carry_d;
  logic carry_q;
  logic zero_d;
  logic zero_q;
`endif

  ula_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i      (a),
    .b_i      (b),
    .opcode_i (opcode),
    .result_o (s_d)
`ifdef ULA_FLAGS_EN
    ,
    .carry_o  (carry_d),
    .zero_o   (zero_d)
`endif
  );

  // Output register: loads every edge, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= {WIDTH{1'b0}};
`ifdef ULA_FLAGS_EN
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      s_q     <= s_d;
`ifdef ULA_FLAGS_EN
      carry_q <= carry_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign s = s_q;
`ifdef ULA_FLAGS_EN
  assign carry = carry_q;
  assign zero  = zero_q;
`endif

endmodule

// File: tb/tb_ula.sv
// Directed scoreboard bench for ula; flag checks are compiled in only with ULA_FLAGS_EN.
module tb_ula;
  import ula_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic [7:0] s;
`ifdef ULA_FLAGS_EN
  logic       carry;
  logic       zero;
`endif

  ula #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .s      (s)
`ifdef ULA_FLAGS_EN
    ,
    .carry  (carry),
    .zero   (zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] s;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input int av, input int bv, input logic [2:0] op);
    exp_t e;
    int   r;
    e.tag = tag;
    e.c   = 1'b0;
    case (op)
      3'd0: begin r = av + bv; e.c = (r > 255); r = r % 256; end
      3'd1: begin r = av - bv; e.c = (av < bv); if (r < 0) r = r + 256; end
      3'd2: r = av & bv;
      3'd3: r = av | bv;
      3'd4: r = av ^ bv;
      3'd5: r = 255 - av;
      3'd6: r = (av == bv) ? 1 : 0;
      3'd7: r = (av != bv) ? 1 : 0;
      default: r = 0;
    endcase
    e.s = r[7:0];
    e.z = (r == 0);
    return e;
  endfunction

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_s"}, s, e.s);
`ifdef ULA_FLAGS_EN
      chk({e.tag, "_carry"}, {7'd0, carry}, {7'd0, e.c});
      chk({e.tag, "_zero"}, {7'd0, zero}, {7'd0, e.z});
`endif
    end
  endtask

  task automatic step(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic [2:0] op);
    @(negedge clk);
    a      = av;
    b      = bv;
    opcode = op;
    sb.push_back(model(tag, int'(av), int'(bv), op));
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_s"}, s, 8'd0);
`ifdef ULA_FLAGS_EN
    chk({tag, "_carry"}, {7'd0, carry}, 8'd0);
    chk({tag, "_zero"}, {7'd0, zero}, 8'd0);
`endif
  endtask

  initial begin
    rst_n  = 1'b0;
    a      = 8'd0;
    b      = 8'd0;
    opcode = 3'b000;
    #1;
    chk_cleared("reset_init");
    #12;
    @(negedge clk);
    rst_n = 1'b1;

    step("add_5_10",    8'd5,          8'd10,         OP_ADD);
    step("add_200_100", 8'd200,        8'd100,        OP_ADD);
    step("add_255_1",   8'd255,        8'd1,          OP_ADD);
    step("sub_15_10",   8'd15,         8'd10,         OP_SUB);
    step("sub_5_10",    8'd5,          8'd10,         OP_SUB);
    step("sub_7_7",     8'd7,          8'd7,          OP_SUB);
    step("and",         8'b1100_1010,  8'b1010_1100,  OP_AND);
    step("or",          8'b1100_1010,  8'b1010_1100,  OP_OR);
    step("xor",         8'b1100_1010,  8'b1010_1100,  OP_XOR);
    step("not",         8'b1111_0000,  8'b1010_1010,  OP_NOT);
    step("eq_10_10",    8'd10,         8'd10,         OP_EQ);
    step("eq_5_10",     8'd5,          8'd10,         OP_EQ);
    step("neq_10_5",    8'd10,         8'd5,          OP_NEQ);
    step("neq_10_10",   8'd10,         8'd10,         OP_NEQ);

    // Reset while s holds 15, with a new result pending that must be discarded.
    step("pre_rst_add", 8'd5,          8'd10,         OP_ADD);
    @(negedge clk);
    a      = 8'd200;
    b      = 8'd100;
    opcode = OP_ADD;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("rst_async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_cleared("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model("rst_release", 200, 100, OP_ADD));
    #1;
    chk_cleared("rst_release_pre");
    @(posedge clk);
    #1;
    check_pop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
